// File: rtl/ber_checker.sv
// ber_checker: BER measurement stage behind the 4x oversampled RC FIR.
//   Decimates the FIR output by 4 at phase i_phase and slices on the sign bit.
//   Searches the reference delay line for a window with zero errors, then
//   locks and accumulates bit and error counts (saturating).
// Optional feature macro: BER_LOSS_OF_LOCK_EN. When defined, the error window
//   also runs while locked. LOL_THRESH or more errors in one window drop lock
//   and restart the search from delay 0.
// Ports:
//   clock, i_reset      clock, asynchronous active-high reset
//   i_enable            global enable; 0 freezes all state
//   i_data              signed FIR sample, one per enabled clock
//   i_phase             decimation phase 0..3
//   i_ref, i_ref_valid  transmitted reference bit and its qualifier
//   i_clear             synchronous clear of the accumulators
//   o_locked, o_delay   lock flag and current/locked reference delay
//   o_bit_count         bits compared while locked
//   o_err_count         mismatches while locked
module ber_checker #(
  parameter int unsigned NB_INPUT   = 8,
  parameter int unsigned NB_COUNT   = 64,
  parameter int unsigned NB_DELAY   = 9,
  parameter int unsigned NB_WIN     = 9,
  parameter int unsigned LOL_THRESH = 16
) (
  input  logic                       clock,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic signed [NB_INPUT-1:0] i_data,
  input  logic [1:0]                 i_phase,
  input  logic                       i_ref,
  input  logic                       i_ref_valid,
  input  logic                       i_clear,
  output logic                       o_locked,
  output logic [NB_DELAY-1:0]        o_delay,
  output logic [NB_COUNT-1:0]        o_bit_count,
  output logic [NB_COUNT-1:0]        o_err_count
);

  localparam int unsigned DEPTH   = 1 << NB_DELAY;
  localparam int unsigned NB_WERR = NB_WIN + 1;

  // The threshold must be reachable inside one window.
  if (LOL_THRESH < 1 || LOL_THRESH > (1 << NB_WIN)) begin : g_bad_lol_thresh
    $error("ber_checker: LOL_THRESH must be in 1..2**NB_WIN");
  end

  typedef enum logic [0:0] {ST_SEARCH = 1'b0, ST_LOCKED = 1'b1} state_t;

  state_t               state_q,    state_d;
  logic [1:0]           phase_q,    phase_d;
  logic [DEPTH-1:0]     line_q,     line_d;
  logic [NB_DELAY-1:0]  delay_q,    delay_d;
  logic                 locked_q,   locked_d;
  logic [NB_COUNT-1:0]  bit_cnt_q,  bit_cnt_d;
  logic [NB_COUNT-1:0]  err_cnt_q,  err_cnt_d;
  logic [NB_WIN-1:0]    win_bits_q, win_bits_d;
  logic [NB_WERR-1:0]   win_err_q,  win_err_d;

  logic                 strobe;
  logic                 rx_bit;
  logic                 ref_bit;
  logic                 err;
  logic                 win_last;
  logic [NB_WERR-1:0]   win_total;
  logic                 unused_data;

  // Only the sign of the sample carries the decision.
  assign unused_data = ^i_data[NB_INPUT-2:0];

  assign strobe    = i_enable && (phase_q == i_phase);
  assign rx_bit    = i_data[NB_INPUT-1];
  assign ref_bit   = line_q[delay_q];
  assign err       = rx_bit ^ ref_bit;
  // Window ends on the strobe that brings the bit count to 2**NB_WIN.
  assign win_last  = (win_bits_q == '1);
  assign win_total = win_err_q + NB_WERR'(err);

  // Next-state logic.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    line_d     = line_q;
    delay_d    = delay_q;
    locked_d   = locked_q;
    bit_cnt_d  = bit_cnt_q;
    err_cnt_d  = err_cnt_q;
    win_bits_d = win_bits_q;
    win_err_d  = win_err_q;

    if (i_enable) begin
      phase_d = phase_q + 2'd1;
      if (i_ref_valid) begin
        line_d = {line_q[DEPTH-2:0], i_ref};
      end
    end

    if (strobe) begin
      case (state_q)
        ST_SEARCH: begin
          win_bits_d = win_bits_q + 1'b1;
          win_err_d  = win_total;
          if (win_last) begin
            win_bits_d = '0;
            win_err_d  = '0;
            if (win_total == '0) begin
              state_d  = ST_LOCKED;
              locked_d = 1'b1;
            end else begin
              delay_d = delay_q + 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (bit_cnt_q != '1) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
          if (err && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + 1'b1;
          end
`ifdef BER_LOSS_OF_LOCK_EN
          win_bits_d = win_bits_q + 1'b1;
          win_err_d  = win_total;
          if (win_last) begin
            win_bits_d = '0;
            win_err_d  = '0;
            if (win_total >= NB_WERR'(LOL_THRESH)) begin
              state_d  = ST_SEARCH;
              locked_d = 1'b0;
              delay_d  = '0;
            end
          end
`else
          win_bits_d = win_bits_q;
          win_err_d  = win_err_q;
`endif
        end
        default: begin
          state_d = ST_SEARCH;
        end
      endcase
    end

    // Clear overrides any count from a coincident strobe.
    if (i_enable && i_clear) begin
      bit_cnt_d = '0;
      err_cnt_d = '0;
    end
  end

  // State registers.
  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= ST_SEARCH;
      phase_q    <= '0;
      line_q     <= '0;
      delay_q    <= '0;
      locked_q   <= 1'b0;
      bit_cnt_q  <= '0;
      err_cnt_q  <= '0;
      win_bits_q <= '0;
      win_err_q  <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      line_q     <= line_d;
      delay_q    <= delay_d;
      locked_q   <= locked_d;
      bit_cnt_q  <= bit_cnt_d;
      err_cnt_q  <= err_cnt_d;
      win_bits_q <= win_bits_d;
      win_err_q  <= win_err_d;
    end
  end

  assign o_locked    = locked_q;
  assign o_delay     = delay_q;
  assign o_bit_count = bit_cnt_q;
  assign o_err_count = err_cnt_q;

endmodule

// File: tb/tb_ber_checker.sv
// tb_ber_checker: self-checking bench for ber_checker.
//   Two instances share clock, reset and reference: the main one with 64-bit
//   counters and a second one with 8-bit counters for saturation. Received
//   samples are the reference delayed 5 bits, mapped to +/- magnitudes.
module tb_ber_checker;

  logic       clock;
  logic       i_reset;
  logic       i_enable;
  logic [7:0] i_data;
  logic [7:0] s_data;
  logic [1:0] i_phase;
  logic       i_ref;
  logic       i_ref_valid;
  logic       i_clear;
  logic       o_locked;
  logic [8:0] o_delay;
  logic [63:0] o_bit_count;
  logic [63:0] o_err_count;
  logic       s_locked;
  logic [8:0] s_delay;
  logic [7:0] s_bits;
  logic [7:0] s_errs;

  ber_checker dut (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_data(i_data),
    .i_phase(i_phase), .i_ref(i_ref), .i_ref_valid(i_ref_valid),
    .i_clear(i_clear), .o_locked(o_locked), .o_delay(o_delay),
    .o_bit_count(o_bit_count), .o_err_count(o_err_count)
  );

  ber_checker #(.NB_COUNT(8)) dut_s (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_data(s_data),
    .i_phase(i_phase), .i_ref(i_ref), .i_ref_valid(i_ref_valid),
    .i_clear(i_clear), .o_locked(s_locked), .o_delay(s_delay),
    .o_bit_count(s_bits), .o_err_count(s_errs)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: a history queue (index 0 = newest bit) plus per-instance
  // lock state, delay, window tallies and saturating accumulators.
  bit              m_line[$];
  int              m_pcnt;
  bit              m_locked[2];
  int              m_delay[2];
  longint unsigned m_bits[2];
  longint unsigned m_errs[2];
  longint unsigned m_max[2];
  int              m_wbits[2];
  int              m_werr[2];

  logic [8:0] lfsr = 9'h1FF;
  int         ref_slot = 0;
  bit         drv_strobe;

  typedef struct {
    bit en; bit clr; bit flip; int exp_bits; int exp_errs;
  } vec_t;
  vec_t tbl[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 30) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_line = {};
    repeat (512) m_line.push_back(1'b0);
    m_pcnt = 0;
    for (int k = 0; k < 2; k++) begin
      m_locked[k] = 1'b0; m_delay[k] = 0; m_bits[k] = 0; m_errs[k] = 0;
      m_wbits[k] = 0; m_werr[k] = 0;
    end
  endtask

  task automatic model_step();
    bit         strobe;
    bit         err;
    logic [7:0] d;
    if (!i_enable) return;
    strobe = (m_pcnt == int'(i_phase));
    for (int k = 0; k < 2; k++) begin
      d = (k == 0) ? i_data : s_data;
      if (strobe) begin
        err = d[7] ^ m_line[m_delay[k]];
        if (!m_locked[k]) begin
          m_wbits[k]++;
          m_werr[k] += int'(err);
          if (m_wbits[k] == 512) begin
            if (m_werr[k] == 0) m_locked[k] = 1'b1;
            else m_delay[k] = (m_delay[k] + 1) % 512;
            m_wbits[k] = 0; m_werr[k] = 0;
          end
        end else begin
          if (m_bits[k] < m_max[k]) m_bits[k]++;
          if (err && m_errs[k] < m_max[k]) m_errs[k]++;
`ifdef BER_LOSS_OF_LOCK_EN
          m_wbits[k]++;
          m_werr[k] += int'(err);
          if (m_wbits[k] == 512) begin
            if (m_werr[k] >= 16) begin
              m_locked[k] = 1'b0; m_delay[k] = 0;
            end
            m_wbits[k] = 0; m_werr[k] = 0;
          end
`endif
        end
      end
      if (i_clear) begin
        m_bits[k] = 0; m_errs[k] = 0;
      end
    end
    if (i_ref_valid) m_line = {i_ref, m_line[0:510]};
    m_pcnt = (m_pcnt + 1) % 4;
  endtask

  task automatic compare_all();
    check("locked", 64'(o_locked), 64'(m_locked[0]));
    check("delay", 64'(o_delay), 64'(m_delay[0]));
    check("bit_count", o_bit_count, m_bits[0]);
    check("err_count", o_err_count, m_errs[0]);
    check("s_locked", 64'(s_locked), 64'(m_locked[1]));
    check("s_delay", 64'(s_delay), 64'(m_delay[1]));
    check("s_bit_count", 64'(s_bits), m_bits[1]);
    check("s_err_count", 64'(s_errs), m_errs[1]);
  endtask

  task automatic tick();
    @(posedge clock);
    if (i_reset) model_reset();
    else model_step();
    #1;
    compare_all();
  endtask

  function automatic logic [7:0] sample(input bit b);
    if (b) return 8'(-int'($urandom_range(128, 1)));
    return 8'($urandom_range(127, 0));
  endfunction

  // Sets inputs for the next edge; samples on strobe clocks carry the
  // reference bit from 5 positions back, optionally inverted.
  task automatic drive(input bit en, input bit clr, input bit flip0, input bit flip1);
    bit  ideal;
    bit  nb;
    i_enable   = en;
    i_clear    = clr;
    drv_strobe = en && (m_pcnt == int'(i_phase));
    ideal      = m_line[5];
    i_data     = drv_strobe ? sample(ideal ^ flip0) : 8'($urandom);
    s_data     = drv_strobe ? sample(ideal ^ flip1) : 8'($urandom);
    ref_slot   = (ref_slot + 1) % 4;
    i_ref_valid = (ref_slot == 0);
    if (i_ref_valid) begin
      nb   = lfsr[8] ^ lfsr[4];
      lfsr = {lfsr[7:0], nb};
      i_ref = nb;
    end else begin
      i_ref = 1'($urandom);
    end
  endtask

  initial begin
    int lock_at;
    int n;
    bit snap_locked;
    int snap_delay;
    longint unsigned snap_bits;
    longint unsigned snap_errs;

    tbl[0]  = '{1, 0, 0, 1, 0};
    tbl[1]  = '{1, 0, 0, 1, 0};
    tbl[2]  = '{1, 0, 0, 1, 0};
    tbl[3]  = '{1, 0, 0, 1, 0};
    tbl[4]  = '{1, 1, 1, 0, 0};
    tbl[5]  = '{1, 0, 0, 0, 0};
    tbl[6]  = '{1, 0, 0, 0, 0};
    tbl[7]  = '{1, 0, 0, 0, 0};
    tbl[8]  = '{1, 0, 1, 1, 1};
    tbl[9]  = '{0, 0, 0, 1, 1};
    tbl[10] = '{0, 0, 0, 1, 1};
    tbl[11] = '{1, 0, 0, 1, 1};
    tbl[12] = '{1, 0, 0, 1, 1};
    tbl[13] = '{1, 0, 0, 1, 1};
    tbl[14] = '{1, 0, 0, 2, 1};
    tbl[15] = '{1, 1, 0, 0, 0};

    m_max[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    m_max[1] = 64'd255;
    model_reset();
    i_reset = 1'b1; i_enable = 1'b0; i_data = '0; s_data = '0; i_phase = 2'd0;
    i_ref = 1'b0; i_ref_valid = 1'b0; i_clear = 1'b0;

    // Reset state
    drive(1, 0, 0, 0);
    tick();
    tick();
    check("rst_locked", 64'(o_locked), 64'd0);
    check("rst_delay", 64'(o_delay), 64'd0);
    check("rst_bits", o_bit_count, 64'd0);
    check("rst_errs", o_err_count, 64'd0);
    i_reset = 1'b0;

    // Acquisition: delays 0..4 fail, delay 5 is clean -> lock after 6 windows
    lock_at = -1;
    n = 0;
    for (int c = 0; c < 20000 && lock_at < 0; c++) begin
      drive(1, 0, 0, 0);
      if (drv_strobe) n++;
      tick();
      if (o_locked === 1'b1) lock_at = n;
    end
    check("lock_strobes", 64'(lock_at), 64'd3072);
    check("lock_delay", 64'(o_delay), 64'd5);
    check("lock_bits", o_bit_count, 64'd0);

    // Table: strobe counting, clear-wins, enable freeze
    for (int c = 0; c < 4 && m_pcnt != 0; c++) begin
      drive(1, 0, 0, 0);
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].en, tbl[i].clr, tbl[i].flip, 1'b0);
      tick();
      check("tbl_bits", o_bit_count, 64'(tbl[i].exp_bits));
      check("tbl_errs", o_err_count, 64'(tbl[i].exp_errs));
      check("tbl_locked", 64'(o_locked), 64'd1);
      check("tbl_delay", 64'(o_delay), 64'd5);
    end

    // Every 100th bit inverted over 1000 bits, then clear
    drive(1, 1, 0, 0);
    tick();
    n = 0;
    for (int c = 0; c < 8000 && n < 1000; c++) begin
      drive(1, 0, (n % 100) == 99, 0);
      if (drv_strobe) n++;
      tick();
    end
    check("ber_bits", o_bit_count, 64'd1000);
    check("ber_errs", o_err_count, 64'd10);
    drive(1, 1, 0, 0);
    tick();
    check("clr_bits", o_bit_count, 64'd0);
    check("clr_errs", o_err_count, 64'd0);

    // Random enable, clear, phase changes and sparse errors
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(99, 0) == 0) i_phase = 2'($urandom);
      drive($urandom_range(9, 0) != 0, $urandom_range(99, 0) == 0,
            $urandom_range(99, 0) == 0, $urandom_range(99, 0) == 0);
      tick();
    end
    i_phase = 2'd0;

    // 20 errors at the start of one window
    drive(1, 1, 0, 0);
    tick();
    for (int c = 0; c < 4000 && m_wbits[0] != 0; c++) begin
      drive(1, 0, 0, 0);
      tick();
    end
    n = 0;
    for (int c = 0; c < 4000 && n < 600; c++) begin
      drive(1, 0, n < 20, 0);
      if (drv_strobe) n++;
      tick();
    end
`ifdef BER_LOSS_OF_LOCK_EN
    check("lol_locked", 64'(o_locked), 64'd0);
    check("lol_delay", 64'(o_delay), 64'd0);
    check("lol_errs", o_err_count, 64'd20);
`else
    check("lol_locked", 64'(o_locked), 64'd1);
    check("lol_delay", 64'(o_delay), 64'd5);
    check("lol_errs", o_err_count, 64'd20);
`endif

    // Saturation of the 8-bit instance
    drive(1, 1, 0, 0);
    tick();
    n = 0;
    for (int c = 0; c < 4000 && n < 300; c++) begin
      drive(1, 0, 0, 1);
      if (drv_strobe) n++;
      tick();
    end
`ifndef BER_LOSS_OF_LOCK_EN
    check("sat_bits", 64'(s_bits), 64'd255);
    check("sat_errs", 64'(s_errs), 64'd255);
    check("sat_main_bits", o_bit_count, 64'd300);
    check("sat_main_errs", o_err_count, 64'd0);
`endif

    // Enable low for 50 clocks
    snap_locked = m_locked[0];
    snap_delay  = m_delay[0];
    snap_bits   = m_bits[0];
    snap_errs   = m_errs[0];
    for (int c = 0; c < 50; c++) begin
      drive(0, 0, 1, 1);
      tick();
    end
    check("frz_locked", 64'(o_locked), 64'(snap_locked));
    check("frz_delay", 64'(o_delay), 64'(snap_delay));
    check("frz_bits", o_bit_count, snap_bits);
    check("frz_errs", o_err_count, snap_errs);
    for (int c = 0; c < 40; c++) begin
      drive(1, 0, 0, 0);
      tick();
    end

    // Asynchronous reset between edges
    drive(1, 0, 0, 0);
    tick();
    #2 i_reset = 1'b1;
    #1;
    check("arst_locked", 64'(o_locked), 64'd0);
    check("arst_delay", 64'(o_delay), 64'd0);
    check("arst_bits", o_bit_count, 64'd0);
    check("arst_errs", o_err_count, 64'd0);
    check("arst_s_locked", 64'(s_locked), 64'd0);
    check("arst_s_bits", 64'(s_bits), 64'd0);
    tick();
    tick();
    i_reset = 1'b0;
    for (int c = 0; c < 200; c++) begin
      drive(1, 0, 0, 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
